regwrite_arbiter: RTL

Shares the register bank's single write port among three requesters: pipeline writeback (WB), the multi-cycle load-return unit (LD), and the syscall/host injection path (SYS). WB has strict priority, LD and SYS alternate round-robin, and a per-requester starvation counter forces a WB stall when a lower-priority request has waited too long. The block sits between those requesters and the register bank's write inputs (write-enable, write address, write data), and drives them from a registered output stage.

---
 rtl/regwrite_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//   Shares the register bank's single write port among three requesters:
//   pipeline writeback (WB), load-return (LD) and syscall/host injection (SYS).
//   WB has strict priority; LD and SYS alternate round-robin. A per-requester
//   starvation counter forces WB to stall once LD or SYS has been refused
//   STARVE_LIMIT times. The write port is driven from a registered stage.
//
// Ports
//   iCLK, iCLR                    clock, async active-low reset
//   iWbValid/iWbReg/iWbData       WB request, oWbReady accepts it
//   iLdValid/iLdReg/iLdData       LD request, oLdReady accepts it
//   iSysValid/iSysReg/iSysData    SYS request, oSysReady accepts it
//   oRegWrite                     bank write enable (registered)
//   oWriteRegister, oWriteData    bank write address / data (registered)
//   oStall                        WB valid but refused due to starvation
module regwrite_arbiter #(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              iCLK,
  input  logic              iCLR,
  input  logic              iWbValid,
  input  logic [4:0]        iWbReg,
  input  logic [DATA_W-1:0] iWbData,
  output logic              oWbReady,
  input  logic              iLdValid,
  input  logic [4:0]        iLdReg,
  input  logic [DATA_W-1:0] iLdData,
  output logic              oLdReady,
  input  logic              iSysValid,
  input  logic [4:0]        iSysReg,
  input  logic [DATA_W-1:0] iSysData,
  output logic              oSysReady,
  output logic              oRegWrite,
  output logic [4:0]        oWriteRegister,
  output logic [DATA_W-1:0] oWriteData,
  output logic              oStall
);

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LD,
    GNT_SYS
  } grant_e;

  grant_e            grant;
  logic              rr;          // 0 favours LD, 1 favours SYS
  logic [3:0]        starve_ld;
  logic [3:0]        starve_sys;
  logic              cand_ld;
  logic              cand_sys;
  logic [4:0]        sel_reg;
  logic [DATA_W-1:0] sel_data;

  // A saturated counter only forces a grant while its requester is still
  // presenting a request, so an idle starved requester cannot stall WB.
  assign cand_ld  = iLdValid  && (starve_ld  == LIMIT);
  assign cand_sys = iSysValid && (starve_sys == LIMIT);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else tree can leave a value unassigned (latch).
  always_comb begin
    grant  = GNT_NONE;
    oStall = 1'b0;
    if (cand_ld || cand_sys) begin
      if (cand_ld && cand_sys) grant = rr ? GNT_SYS : GNT_LD;
      else                     grant = cand_ld ? GNT_LD : GNT_SYS;
      oStall = iWbValid;
    end else if (iWbValid) begin
      grant = GNT_WB;
    end else if (iLdValid && iSysValid) begin
      grant = rr ? GNT_SYS : GNT_LD;
    end else if (iLdValid) begin
      grant = GNT_LD;
    end else if (iSysValid) begin
      grant = GNT_SYS;
    end
    // Nothing is accepted while reset is held; requesters re-present after.
    if (!iCLR) begin
      grant  = GNT_NONE;
      oStall = 1'b0;
    end
  end

  assign oWbReady  = (grant == GNT_WB);
  assign oLdReady  = (grant == GNT_LD);
  assign oSysReady = (grant == GNT_SYS);

  always_comb begin
    sel_reg  = iWbReg;
    sel_data = iWbData;
    case (grant)
      GNT_LD:  begin sel_reg = iLdReg;  sel_data = iLdData;  end
      GNT_SYS: begin sel_reg = iSysReg; sel_data = iSysData; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iCLK or negedge iCLR) begin
    if (!iCLR) begin
      rr             <= 1'b0;
      starve_ld      <= '0;
      starve_sys     <= '0;
      oRegWrite      <= 1'b0;
      oWriteRegister <= '0;
      oWriteData     <= '0;
    end else begin
      // Round-robin pointer moves past whichever of LD/SYS was served.
      if (grant == GNT_LD)       rr <= 1'b1;
      else if (grant == GNT_SYS) rr <= 1'b0;

      if (grant == GNT_LD)                          starve_ld <= '0;
      else if (iLdValid && starve_ld != LIMIT)      starve_ld <= starve_ld + 4'd1;

      if (grant == GNT_SYS)                         starve_sys <= '0;
      else if (iSysValid && starve_sys != LIMIT)    starve_sys <= starve_sys + 4'd1;

      if (grant != GNT_NONE) begin
        oWriteRegister <= sel_reg;
        oWriteData     <= sel_data;
        // Register 31 is hard-wired zero: the request is consumed, no write.
        oRegWrite      <= (sel_reg != ZERO_REG);
      end else begin
        oRegWrite      <= 1'b0;
      end
    end
  end

endmodule
